// File: rtl/arith_op_pkg.sv
// Shared types for the arithmetic operation scheduler and its datapath.
package arith_op_pkg;

  typedef enum logic [1:0] {
    OP_ADDITION     = 2'b00,
    OP_SUBSTRACTION = 2'b01,
    OP_AND          = 2'b10,
    OP_OR           = 2'b11
  } op_options_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/arith_operator.sv
// Combinational shared arithmetic unit: wrapping add/sub and bitwise and/or.
module arith_operator
  import arith_op_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_SEL  = 2
) (
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_SEL-1:0]  i_sel,
  output logic [NB_DATA-1:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_sel)
      NB_SEL'(OP_ADDITION):     o_data = i_data_a + i_data_b;
      NB_SEL'(OP_SUBSTRACTION): o_data = i_data_a - i_data_b;
      NB_SEL'(OP_AND):          o_data = i_data_a & i_data_b;
      NB_SEL'(OP_OR):           o_data = i_data_a | i_data_b;
      default:                  o_data = '0;
    endcase
  end

endmodule

// File: rtl/arith_rr_picker.sv
// Round-robin priority search: first valid requester after the last grant, wrapping.
module arith_rr_picker
  import arith_op_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int NB_ID = 2
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [NB_ID-1:0] i_last_grant,
  output logic [NB_ID-1:0] o_grant,
  output logic             o_grant_found
);

  int               cand_idx;
  logic [NB_ID-1:0] cand;

  always_comb begin
    o_grant       = '0;
    o_grant_found = 1'b0;
    cand_idx      = 0;
    cand          = '0;
    // The last granted requester is visited last, giving it lowest priority.
    for (int i = 1; i <= N_REQ; i++) begin
      cand_idx = (int'(i_last_grant) + i) % N_REQ;
      cand     = cand_idx[NB_ID-1:0];
      if (!o_grant_found && i_valid[cand]) begin
        o_grant       = cand;
        o_grant_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arith_op_scheduler.sv
// Shares one arith_operator among N_REQ requesters: round-robin grant,
// registered operands, registered result tagged with the requester ID.
module arith_op_scheduler
  import arith_op_pkg::*;
#(
  parameter  int NB_DATA = 16,
  parameter  int NB_SEL  = 2,
  parameter  int N_REQ   = 4,
  localparam int NB_ID   = $clog2(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req_valid,
  output logic [N_REQ-1:0]         o_req_ready,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data_a,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data_b,
  input  logic [N_REQ*NB_SEL-1:0]  i_req_sel,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [NB_DATA-1:0]       o_rsp_data,
  output logic [NB_ID-1:0]         o_rsp_id
);

  sched_state_e     state_q, state_d;
  logic [NB_ID-1:0] last_grant_q, last_grant_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_SEL-1:0]  sel_q, sel_d;
  logic [NB_ID-1:0]   id_q, id_d;
  logic [NB_DATA-1:0] rsp_data_q, rsp_data_d;
  logic [NB_ID-1:0]   rsp_id_q, rsp_id_d;
  logic               rsp_valid_q, rsp_valid_d;

  logic [NB_ID-1:0]   grant;
  logic               grant_found;
  logic [NB_DATA-1:0] op_result;

  arith_rr_picker #(
    .N_REQ (N_REQ),
    .NB_ID (NB_ID)
  ) u_picker (
    .i_valid       (i_req_valid),
    .i_last_grant  (last_grant_q),
    .o_grant       (grant),
    .o_grant_found (grant_found)
  );

  arith_operator #(
    .NB_DATA (NB_DATA),
    .NB_SEL  (NB_SEL)
  ) u_operator (
    .i_data_a (a_q),
    .i_data_b (b_q),
    .i_sel    (sel_q),
    .o_data   (op_result)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    id_d         = id_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    o_req_ready  = '0;
    case (state_q)
      IDLE: begin
        // The picker only returns valid requesters, so ready implies the handshake.
        if (grant_found) begin
          o_req_ready  = N_REQ'(1) << grant;
          a_d          = i_req_data_a[int'(grant)*NB_DATA +: NB_DATA];
          b_d          = i_req_data_b[int'(grant)*NB_DATA +: NB_DATA];
          sel_d        = i_req_sel[int'(grant)*NB_SEL +: NB_SEL];
          id_d         = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = op_result;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!i_rst_n) o_req_ready = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= NB_ID'(N_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      id_q         <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      id_q         <= id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_arith_op_scheduler.sv
// Randomized and directed bench for arith_op_scheduler against a transaction-level model.
module tb_arith_op_scheduler;

  localparam int N  = 4;
  localparam int NW = 16;
  localparam int NS = 2;

  logic            i_clk;
  logic            i_rst_n;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    o_req_ready;
  logic [N*NW-1:0] i_req_data_a;
  logic [N*NW-1:0] i_req_data_b;
  logic [N*NS-1:0] i_req_sel;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [NW-1:0]   o_rsp_data;
  logic [1:0]      o_rsp_id;

  arith_op_scheduler #(.NB_DATA(NW), .NB_SEL(NS), .N_REQ(N)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_data_a (i_req_data_a),
    .i_req_data_b (i_req_data_b),
    .i_req_sel    (i_req_sel),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_id     (o_rsp_id)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [NW-1:0] drv_a [N];
  logic [NW-1:0] drv_b [N];
  logic [NS-1:0] drv_sel [N];

  // Transaction-level model: one operation in flight, result visible one edge after accept.
  int            m_ptr;
  bit            m_busy;
  int            m_age;
  int            m_data;
  int            m_id;

  int            n_checks;
  int            n_fail;
  int            cycle_no;
  logic [N-1:0]  last_ready_seen;
  bit            log_grants;
  int            grant_log[$];
  int            grant_cyc[$];

  function automatic int ref_op(input int a, input int b, input int sel);
    case (sel)
      0:       return (a + b) % 65536;
      1:       return (a - b + 65536) % 65536;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int model_pick(input logic [N-1:0] valid_v);
    for (int i = 1; i <= N; i++) begin
      if (valid_v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle_no);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready, advance model.
  task automatic applyStimulus(input logic rst_n_v, input logic [N-1:0] valid_v, input logic rsp_ready_v);
    bit           exp_valid;
    int           g;
    logic [N-1:0] exp_ready;
    exp_valid = m_busy && (m_age >= 1);
    checkOutput("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      checkOutput("rsp_data", {16'd0, o_rsp_data}, m_data);
      checkOutput("rsp_id", {30'd0, o_rsp_id}, m_id);
    end
    i_rst_n     = rst_n_v;
    i_req_valid = valid_v;
    i_rsp_ready = rsp_ready_v;
    for (int k = 0; k < N; k++) begin
      i_req_data_a[k*NW +: NW] = drv_a[k];
      i_req_data_b[k*NW +: NW] = drv_b[k];
      i_req_sel[k*NS +: NS]    = drv_sel[k];
    end
    #1;
    g = model_pick(valid_v);
    exp_ready = (rst_n_v && !m_busy && g >= 0) ? N'(1 << g) : '0;
    checkOutput("req_ready", {28'd0, o_req_ready}, {28'd0, exp_ready});
    last_ready_seen = o_req_ready;
    if (log_grants && o_req_ready != '0) begin
      for (int k = 0; k < N; k++) begin
        if (o_req_ready[k]) begin
          grant_log.push_back(k);
          grant_cyc.push_back(cycle_no);
        end
      end
    end
    if (!rst_n_v) begin
      m_busy = 0;
      m_ptr  = N - 1;
    end else if (m_busy) begin
      if (exp_valid && rsp_ready_v) m_busy = 0;
      else m_age++;
    end else if (g >= 0) begin
      m_busy = 1;
      m_age  = 0;
      m_ptr  = g;
      m_data = ref_op(int'(drv_a[g]), int'(drv_b[g]), int'(drv_sel[g]));
      m_id   = g;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    cycle_no++;
  endtask

  task automatic runDirected(input int k, input logic [NW-1:0] a, input logic [NW-1:0] b,
                             input logic [NS-1:0] sel, input logic [NW-1:0] expected, input string tag);
    drv_a[k] = a;
    drv_b[k] = b;
    drv_sel[k] = sel;
    applyStimulus(1'b1, N'(1 << k), 1'b1);
    checkOutput({tag, "_ready"}, {28'd0, last_ready_seen}, 1 << k);
    applyStimulus(1'b1, '0, 1'b1);
    checkOutput({tag, "_valid"}, {31'd0, o_rsp_valid}, 1);
    checkOutput({tag, "_data"}, {16'd0, o_rsp_data}, {16'd0, expected});
    checkOutput({tag, "_id"}, {30'd0, o_rsp_id}, k);
    applyStimulus(1'b1, '0, 1'b1);
    applyStimulus(1'b1, '0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] rvalid;
    int           fair_order[6];
    fair_order = '{0, 1, 2, 3, 0, 1};
    n_checks = 0; n_fail = 0; cycle_no = 0; log_grants = 0;
    m_ptr = N - 1; m_busy = 0; m_age = 0; m_data = 0; m_id = 0;
    for (int k = 0; k < N; k++) begin
      drv_a[k] = '0; drv_b[k] = '0; drv_sel[k] = '0;
    end
    i_rst_n = 1'b0; i_req_valid = '1; i_rsp_ready = 1'b1;
    i_req_data_a = '0; i_req_data_b = '0; i_req_sel = '0;
    @(negedge i_clk);

    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, '1, 1'b1);
      checkOutput("rst_valid", {31'd0, o_rsp_valid}, 0);
      checkOutput("rst_data", {16'd0, o_rsp_data}, 0);
      checkOutput("rst_id", {30'd0, o_rsp_id}, 0);
    end

    runDirected(2, 16'h0003, 16'h0004, 2'b00, 16'h0007, "add");
    runDirected(0, 16'h0000, 16'h0001, 2'b01, 16'hFFFF, "sub_wrap");
    runDirected(1, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, "add_wrap");
    runDirected(3, 16'hF0F0, 16'h0FF0, 2'b10, 16'h00F0, "and");
    runDirected(3, 16'hF000, 16'h000F, 2'b11, 16'hF00F, "or");

    for (int k = 0; k < N; k++) begin
      drv_a[k] = 16'($urandom); drv_b[k] = 16'($urandom); drv_sel[k] = 2'($urandom);
    end
    log_grants = 1;
    for (int c = 0; c < 16; c++) applyStimulus(1'b1, '1, 1'b1);
    log_grants = 0;
    checkOutput("fair_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      checkOutput("fair_order", grant_log[i], fair_order[i]);
      if (i > 0) checkOutput("fair_interval", grant_cyc[i] - grant_cyc[i-1], 3);
    end
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, '0, 1'b1);

    drv_a[3] = 16'h1234; drv_b[3] = 16'h0101; drv_sel[3] = 2'b00;
    drv_a[0] = 16'h0005; drv_b[0] = 16'h0002; drv_sel[0] = 2'b01;
    applyStimulus(1'b1, 4'b1000, 1'b0);
    checkOutput("bp_first_ready", {28'd0, last_ready_seen}, 4'b1000);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_valid", {31'd0, o_rsp_valid}, 1);
      checkOutput("bp_data", {16'd0, o_rsp_data}, 16'h1335);
      checkOutput("bp_id", {30'd0, o_rsp_id}, 3);
      applyStimulus(1'b1, 4'b0001, 1'b0);
      checkOutput("bp_ready_held", {28'd0, last_ready_seen}, 0);
    end
    applyStimulus(1'b1, 4'b0001, 1'b1);
    checkOutput("bp_ready_on_release", {28'd0, last_ready_seen}, 0);
    applyStimulus(1'b1, 4'b0001, 1'b1);
    checkOutput("bp_accept_after", {28'd0, last_ready_seen}, 4'b0001);
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, '0, 1'b1);

    drv_a[1] = 16'h0011; drv_b[1] = 16'h0022; drv_sel[1] = 2'b00;
    applyStimulus(1'b1, 4'b0010, 1'b1);
    checkOutput("midrst_accept", {28'd0, last_ready_seen}, 4'b0010);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("midrst_no_rsp", {31'd0, o_rsp_valid}, 0);
    applyStimulus(1'b1, 4'b0011, 1'b1);
    checkOutput("midrst_req0_first", {28'd0, last_ready_seen}, 4'b0001);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, '0, 1'b1);

    rvalid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (rvalid[k] && !last_ready_seen[k]) begin
          if ($urandom_range(0, 7) == 0) rvalid[k] = 1'b0;
        end else begin
          rvalid[k] = 1'($urandom_range(0, 1));
          if (rvalid[k]) begin
            drv_a[k] = 16'($urandom); drv_b[k] = 16'($urandom); drv_sel[k] = 2'($urandom);
          end
        end
      end
      applyStimulus(($urandom_range(0, 99) != 0), rvalid, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
